// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame sequencer and its select decoder.
package fft_pkg;

    localparam int SW = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        GAP,
        UNLOAD
    } state_t;

    localparam logic [1:0] M1_SPAN4  = 2'd0;
    localparam logic [1:0] M1_SPAN2  = 2'd1;
    localparam logic [1:0] M1_SPAN1  = 2'd2;
    localparam logic [1:0] M1_BYPASS = 2'd3;

    // The last two stages have butterfly spans of 2 and 1; all earlier stages span >= 4.
    function automatic logic [1:0] m1_for_stage(input logic [SW-1:0] stage, input int numstages);
        if (int'(stage) < numstages - 2) begin
            return M1_SPAN4;
        end else if (int'(stage) == numstages - 2) begin
            return M1_SPAN2;
        end else begin
            return M1_SPAN1;
        end
    endfunction

endpackage

// File: rtl/fft_sel_decode.sv
// Combinational decode of datapath mux selects and twiddle base address from the
// sequencer's registered state, stage number and quad counter.
module fft_sel_decode
    import fft_pkg::*;
#(
    parameter int NUMSTAGES = 8
) (
    input  state_t                 state,
    input  logic [SW-1:0]          stage_num,
    input  logic [NUMSTAGES-3:0]   counter,
    output logic                   m0_s,
    output logic [1:0]             m1_s,
    output logic                   m2_s,
    output logic                   m3_s,
    output logic [NUMSTAGES-2:0]   tw_addr
);

    localparam int TW = NUMSTAGES - 1;

    // Shifting inside a TW-bit vector makes the address wrap modulo N/2 for free.
    logic [TW-1:0] tw_base;
    assign tw_base = {counter, 1'b0};

    always_comb begin
        m0_s    = 1'b0;
        m1_s    = M1_BYPASS;
        m2_s    = 1'b0;
        m3_s    = 1'b0;
        tw_addr = '0;
        case (state)
            LOAD: begin
                m0_s = 1'b1;
            end
            COMPUTE, GAP: begin
                m1_s    = m1_for_stage(stage_num, NUMSTAGES);
                m2_s    = ~stage_num[0];
                tw_addr = tw_base << stage_num;
            end
            UNLOAD: begin
                m3_s = 1'b1;
                m2_s = ~stage_num[0];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer for an N-point radix-2 FFT core: LOAD, NUMSTAGES compute passes
// separated by pipeline-drain gaps, then UNLOAD.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int NUMSTAGES = 8,
    parameter int PIPE_LAT  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  inv,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUMSTAGES-3:0]  counter_r,
    output logic [SW-1:0]         stage_num_r,
    output logic                  m0_s,
    output logic [1:0]            m1_s,
    output logic                  m2_s,
    output logic                  m3_s,
    output logic [NUMSTAGES-2:0]  tw_addr,
    output logic                  tw_conj,
    output logic                  busy,
    output logic                  done
);

    localparam int GW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [GW-1:0] GAP_LAST   = GW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [SW-1:0] LAST_STAGE = SW'(NUMSTAGES - 1);

    state_t        state_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic          inv_reg;
    logic          done_reg;
    logic          counter_max;

    assign counter_max = &counter_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            counter_r   <= '0;
            stage_num_r <= '0;
            gap_cnt_reg <= '0;
            inv_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= LOAD;
                        inv_reg     <= inv;
                        counter_r   <= '0;
                        stage_num_r <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        counter_r <= counter_r + 1'b1;
                        if (counter_max) begin
                            stage_num_r <= '0;
                            state_reg   <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    counter_r <= counter_r + 1'b1;
                    if (counter_max) begin
                        if (PIPE_LAT != 0) begin
                            state_reg   <= GAP;
                            gap_cnt_reg <= '0;
                        end else if (stage_num_r == LAST_STAGE) begin
                            state_reg <= UNLOAD;
                        end else begin
                            stage_num_r <= stage_num_r + 1'b1;
                        end
                    end
                end
                GAP: begin
                    // Stage number stays put through the gap so the selects hold steady.
                    if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_reg <= '0;
                        if (stage_num_r == LAST_STAGE) begin
                            state_reg <= UNLOAD;
                        end else begin
                            stage_num_r <= stage_num_r + 1'b1;
                            state_reg   <= COMPUTE;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        counter_r <= counter_r + 1'b1;
                        if (counter_max) begin
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == LOAD);
    assign out_valid = (state_reg == UNLOAD);
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign tw_conj   = inv_reg;

    fft_sel_decode #(
        .NUMSTAGES (NUMSTAGES)
    ) u_sel_decode (
        .state     (state_reg),
        .stage_num (stage_num_r),
        .counter   (counter_r),
        .m0_s      (m0_s),
        .m1_s      (m1_s),
        .m2_s      (m2_s),
        .m3_s      (m3_s),
        .tw_addr   (tw_addr)
    );

endmodule
